// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with valid/ready intake and frame/done strobes.
// Optional even-parity bit after the data bits is enabled by defining PISO_PARITY_EN.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             frame_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic accept;
  logic last_bit;

  assign accept   = valid_i & ready_o;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY:  state_d = accept ? SHIFT : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM output: intake is open when idle or in the final cycle of a frame.
  always_comb begin
    ready_o = 1'b0;
    case (state_q)
      IDLE:    ready_o = 1'b1;
`ifdef PISO_PARITY_EN
      SHIFT:   ready_o = 1'b0;
      PARITY:  ready_o = 1'b1;
`else
      SHIFT:   ready_o = last_bit;
`endif
      default: ready_o = 1'b0;
    endcase
  end

  // Datapath next values; output flops default to the idle line level.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b1;
    frame_d = 1'b0;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      // The first bit goes straight to the output flop; the register keeps the rest.
      cnt_d   = '0;
      frame_d = 1'b1;
      if (MSB_FIRST) begin
        ser_d   = data_i[WIDTH-1];
        shreg_d = {data_i[WIDTH-2:0], 1'b1};
      end else begin
        ser_d   = data_i[0];
        shreg_d = {1'b1, data_i[WIDTH-1:1]};
      end
`ifdef PISO_PARITY_EN
      parity_d = ^data_i;
`endif
    end else if (state_q == SHIFT) begin
      if (cnt_q != LAST) begin
        cnt_d   = cnt_q + 1'b1;
        frame_d = 1'b1;
`ifndef PISO_PARITY_EN
        done_d  = (cnt_q == PRE_LAST);
`endif
        if (MSB_FIRST) begin
          ser_d   = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
        end else begin
          ser_d   = shreg_q[0];
          shreg_d = {1'b1, shreg_q[WIDTH-1:1]};
        end
      end else begin
        cnt_d = '0;
`ifdef PISO_PARITY_EN
        ser_d   = parity_q;
        frame_d = 1'b1;
        done_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      ser_q    <= 1'b1;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ser_q    <= ser_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ser_o   = ser_q;
  assign frame_o = frame_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue of expected line beats.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_LEN = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data = '0;
  logic         valid = 1'b0;
  logic         ready_m, ser_m, frame_m, done_m;
  logic         ready_l, ser_l, frame_l, done_l;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_seen = 0;
  int done_seen  = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
    .ready_o(ready_m), .ser_o(ser_m), .frame_o(frame_m), .done_o(done_m));

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
    .ready_o(ready_l), .ser_o(ser_l), .frame_o(frame_l), .done_o(done_l));

  // One entry per frame cycle still to appear on the line; q[0] is the current cycle.
  typedef struct packed {
    logic ser_m;
    logic ser_l;
    logic done;
  } beat_t;

  beat_t q[$];

  task automatic push_word(input logic [W-1:0] w);
    beat_t b;
    for (int i = 0; i < W; i++) begin
      b.ser_m = w[W-1-i];
      b.ser_l = w[i];
      b.done  = (i == W - 1) && !PAR;
      q.push_back(b);
    end
    if (PAR) begin
      b.ser_m = ^w;
      b.ser_l = ^w;
      b.done  = 1'b1;
      q.push_back(b);
    end
  endtask

  // Called at a falling edge: compare the current cycle, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    beat_t cur;
    logic  exp_ready, exp_frame;
    exp_ready = (q.size() <= 1);
    if (q.size() > 0) begin
      cur = q[0];
      exp_frame = 1'b1;
    end else begin
      cur.ser_m = 1'b1;
      cur.ser_l = 1'b1;
      cur.done  = 1'b0;
      exp_frame = 1'b0;
    end
    if (frame_m === 1'b1) frame_seen++;
    if (done_m === 1'b1)  done_seen++;

    n_tests++; if (ser_m !== cur.ser_m) begin n_fail++; $display("FAIL ser_msb t=%0t got %b exp %b", $time, ser_m, cur.ser_m); end
    n_tests++; if (ser_l !== cur.ser_l) begin n_fail++; $display("FAIL ser_lsb t=%0t got %b exp %b", $time, ser_l, cur.ser_l); end
    n_tests++; if (frame_m !== exp_frame) begin n_fail++; $display("FAIL frame_msb t=%0t got %b exp %b", $time, frame_m, exp_frame); end
    n_tests++; if (frame_l !== exp_frame) begin n_fail++; $display("FAIL frame_lsb t=%0t got %b exp %b", $time, frame_l, exp_frame); end
    n_tests++; if (done_m !== cur.done) begin n_fail++; $display("FAIL done_msb t=%0t got %b exp %b", $time, done_m, cur.done); end
    n_tests++; if (done_l !== cur.done) begin n_fail++; $display("FAIL done_lsb t=%0t got %b exp %b", $time, done_l, cur.done); end
    n_tests++; if (ready_m !== exp_ready) begin n_fail++; $display("FAIL ready_msb t=%0t got %b exp %b", $time, ready_m, exp_ready); end
    n_tests++; if (ready_l !== exp_ready) begin n_fail++; $display("FAIL ready_lsb t=%0t got %b exp %b", $time, ready_l, exp_ready); end

    valid = v;
    data  = d;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (v && exp_ready) push_word(d);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++; if ({ser_m, ser_l} !== 2'b11) begin n_fail++; $display("FAIL %s_ser got %b%b exp 11", tag, ser_m, ser_l); end
    n_tests++; if ({frame_m, frame_l} !== 2'b00) begin n_fail++; $display("FAIL %s_frame got %b%b exp 00", tag, frame_m, frame_l); end
    n_tests++; if ({done_m, done_l} !== 2'b00) begin n_fail++; $display("FAIL %s_done got %b%b exp 00", tag, done_m, done_l); end
    n_tests++; if ({ready_m, ready_l} !== 2'b11) begin n_fail++; $display("FAIL %s_ready got %b%b exp 11", tag, ready_m, ready_l); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    q.delete();
    repeat (3) cycle(1'b0, '0);
  endtask

  task automatic test_single_a5();
    cycle(1'b1, 8'hA5);
    repeat (FRAME_LEN + 3) cycle(1'b0, '0);
  endtask

  task automatic test_single_01();
    cycle(1'b1, 8'h01);
    repeat (FRAME_LEN + 3) cycle(1'b0, 8'hFF);
  endtask

  task automatic test_back_to_back();
    frame_seen = 0;
    done_seen  = 0;
    cycle(1'b1, 8'hFF);
    repeat (FRAME_LEN - 1) cycle(1'b1, 8'h00);
    repeat (FRAME_LEN - 1) cycle(1'b1, 8'h00);
    repeat (4) cycle(1'b0, '0);
    n_tests++; if (frame_seen !== 2 * FRAME_LEN) begin n_fail++; $display("FAIL b2b_frame_cycles got %0d exp %0d", frame_seen, 2 * FRAME_LEN); end
    n_tests++; if (done_seen !== 2) begin n_fail++; $display("FAIL b2b_done_pulses got %0d exp 2", done_seen); end
  endtask

  task automatic test_reset_mid_frame();
    cycle(1'b1, 8'hA5);
    repeat (3) cycle(1'b0, '0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst_now");
    q.delete();
    @(posedge clk);
    #1 check_reset_outputs("midrst_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h3C);
    repeat (FRAME_LEN + 3) cycle(1'b0, '0);
  endtask

  task automatic test_busy_ignore();
    cycle(1'b1, 8'h5A);
    for (int i = 0; i < FRAME_LEN - 1; i++)
      cycle(logic'(i % 2 == 0), W'($urandom));
    repeat (4) cycle(1'b0, W'($urandom));
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(logic'($urandom_range(0, 99) < 65), W'($urandom));
    repeat (FRAME_LEN + 2) cycle(1'b0, '0);
  endtask

  task automatic test_parity();
    cycle(1'b1, 8'h07);
    repeat (FRAME_LEN + 2) cycle(1'b0, '0);
    cycle(1'b1, 8'h03);
    repeat (FRAME_LEN + 2) cycle(1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_single_01();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_ignore();
    if (PAR) test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
